data_mem_responder: RTL and testbench

- Responder side of the processor's data-memory load/store interface.
- Accepts one request at a time over a valid/ready handshake, waits a programmable number of cycles, then performs the access and returns a response over a second valid/ready handshake.
- Replaces the zero-latency data array so the core's load/store path can be exercised against a slow memory.

---
 rtl/data_mem_responder_if.sv | 30 +++
 rtl/data_mem_responder.sv | 105 ++++++++++
 tb/tb_data_mem_responder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response handshake bundle for the data-memory responder
//
// Purpose : groups the load/store request channel and the response channel.
// Ports   : req_valid/req_ready/req_write/req_addr/req_wdata  (request channel)
//           resp_valid/resp_ready/resp_rdata/resp_err         (response channel)
// Modports: master = initiator (core side), slave = responder (memory side).
interface data_mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - slow data-memory responder with programmable access latency
//
// Purpose : single-outstanding load/store responder; accepts a request, waits,
//           performs the access, then holds the response until it is taken.
// Ports   : clk        - system clock, all state on rising edge
//           rst        - asynchronous active-high reset
//           bus        - request/response handshake bundle (slave side)
//           busy       - a request is in flight (state is not IDLE)
//           txn_count  - completed response handshakes, wraps at 16 bits
module data_mem_responder #(
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus,
    output logic                  busy,
    output logic [15:0]           txn_count
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              commit;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    assign accept   = bus.req_valid && (state == S_IDLE);
    // The access happens on the edge that leaves WAIT; the counter is loaded
    // with LATENCY so the response shows up LATENCY+1 edges after accept.
    assign commit   = (state == S_WAIT) && (cnt == 4'd0);
    // Full address width is compared so high addresses never alias into the array.
    assign in_range = ({1'b0, lat_addr} < (ADDR_W+1)'(DEPTH));
    assign idx      = lat_addr[IDX_W-1:0];

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            txn_count    <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_write <= bus.req_write;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        cnt       <= 4'(LATENCY);
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state        <= S_RESP;
                        resp_err_q   <= !in_range;
                        resp_rdata_q <= (in_range && !lat_write) ? mem[idx] : '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        state     <= S_IDLE;
                        txn_count <= txn_count + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Array is deliberately outside the reset domain; a store dropped by reset
    // while still in WAIT never reaches here because commit needs state==WAIT.
    always_ff @(posedge clk) begin
        if (!rst && commit && lat_write && in_range) begin
            mem[idx] <= lat_wdata;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (LATENCY=2 and LATENCY=0 builds)
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus2 ();
    data_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();

    logic        busy2, busy0;
    logic [15:0] txn2, txn0;

    assign bus2.req_valid  = req_valid & ~sel;
    assign bus2.req_write  = req_write;
    assign bus2.req_addr   = req_addr;
    assign bus2.req_wdata  = req_wdata;
    assign bus2.resp_ready = resp_ready & ~sel;
    assign bus0.req_valid  = req_valid & sel;
    assign bus0.req_write  = req_write;
    assign bus0.req_addr   = req_addr;
    assign bus0.req_wdata  = req_wdata;
    assign bus0.resp_ready = resp_ready & sel;

    data_mem_responder #(.DEPTH(32), .ADDR_W(8), .DATA_W(32), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .busy(busy2), .txn_count(txn2)
    );
    data_mem_responder #(.DEPTH(32), .ADDR_W(8), .DATA_W(32), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .txn_count(txn0)
    );

    wire        m_req_ready  = sel ? bus0.req_ready  : bus2.req_ready;
    wire        m_resp_valid = sel ? bus0.resp_valid : bus2.resp_valid;
    wire [31:0] m_resp_rdata = sel ? bus0.resp_rdata : bus2.resp_rdata;
    wire        m_resp_err   = sel ? bus0.resp_err   : bus2.resp_err;
    wire        m_busy       = sel ? busy0 : busy2;
    wire [15:0] m_txn        = sel ? txn0  : txn2;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] mdl_mem [2][32];
    int          exp_cnt [2];

    // Scoreboard: expectations pushed on accepted requests, popped on response handshakes.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_cnt[0] = 0;
            exp_cnt[1] = 0;
        end else begin
            if (m_resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    check("resp_unexpected", 64'(1), 64'(0));
                end else begin
                    mon_e = q.pop_front();
                    check("resp_rdata", 64'(m_resp_rdata), 64'(mon_e.rdata));
                    check("resp_err", 64'(m_resp_err), 64'(mon_e.err));
                    if (mon_e.w && mon_e.a < 8'd32) mdl_mem[sel][mon_e.a[4:0]] = mon_e.d;
                    exp_cnt[sel] = exp_cnt[sel] + 1;
                end
            end
            if (req_valid && m_req_ready) begin
                mon_e.w = req_write;
                mon_e.a = req_addr;
                mon_e.d = req_wdata;
                if (req_addr >= 8'd32) begin
                    mon_e.err   = 1'b1;
                    mon_e.rdata = 32'd0;
                end else begin
                    mon_e.err   = 1'b0;
                    mon_e.rdata = req_write ? 32'd0 : mdl_mem[sel][req_addr[4:0]];
                end
                q.push_back(mon_e);
            end
        end
    end

    task automatic do_req(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input int lat, input int hold);
        int          n;
        logic [31:0] rd0;
        logic        er0;
        @(posedge clk); #1;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!m_req_ready && n < 20) begin @(negedge clk); n++; end
        check("req_accept", 64'(m_req_ready), 64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!m_resp_valid && n < 40) begin @(posedge clk); #1; n++; end
        check("latency", 64'(n), 64'(lat + 1));
        check("busy_in_resp", 64'(m_busy), 64'(1));
        rd0 = m_resp_rdata;
        er0 = m_resp_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_addr = 8'h1F; req_write = 1'b1;
            @(negedge clk);
            check("ready_in_resp", 64'(m_req_ready), 64'(0));
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("hold_valid", 64'(m_resp_valid), 64'(1));
            check("hold_rdata", 64'(m_resp_rdata), 64'(rd0));
            check("hold_err", 64'(m_resp_err), 64'(er0));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("valid_drop", 64'(m_resp_valid), 64'(0));
        check("ready_back", 64'(m_req_ready), 64'(1));
        check("busy_idle", 64'(m_busy), 64'(0));
        check("txn_count", 64'(m_txn), 64'(exp_cnt[sel]));
    endtask

    int acc[$];
    int n_drain;

    initial begin
        sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 8'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(m_req_ready), 64'(1));
        check("rst_busy", 64'(m_busy), 64'(0));
        check("rst_resp_valid", 64'(m_resp_valid), 64'(0));
        check("rst_txn_count", 64'(m_txn), 64'(0));
        check("rst_resp_err", 64'(m_resp_err), 64'(0));
        check("rst_resp_rdata", 64'(m_resp_rdata), 64'(0));
        rst = 1'b0;

        // Store then read-after-write.
        do_req(1'b1, 8'd3, 32'h0000_0005, 2, 0);
        do_req(1'b0, 8'd3, 32'h0, 2, 0);
        check("txn_after_two", 64'(m_txn), 64'(2));

        // Backpressure on the response with ignored request pulses.
        do_req(1'b1, 8'd8, 32'h1234_5678, 2, 0);
        do_req(1'b0, 8'd8, 32'h0, 2, 5);

        // Out-of-range accesses must not alias into addr 8.
        do_req(1'b1, 8'd40, 32'hDEAD_BEEF, 2, 0);
        do_req(1'b0, 8'd40, 32'h0, 2, 0);
        do_req(1'b0, 8'd8, 32'h0, 2, 0);
        do_req(1'b0, 8'hFF, 32'h0, 2, 0);
        do_req(1'b1, 8'd31, 32'hCAFE_F00D, 2, 0);
        do_req(1'b0, 8'd31, 32'h0, 2, 0);

        // Reset during WAIT of a store drops it.
        do_req(1'b1, 8'd2, 32'h0000_0011, 2, 0);
        @(posedge clk); #1;
        req_write = 1'b1; req_addr = 8'd2; req_wdata = 32'h0000_00AA; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("wait_busy", 64'(m_busy), 64'(1));
        check("wait_ready", 64'(m_req_ready), 64'(0));
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(m_busy), 64'(0));
        check("midrst_ready", 64'(m_req_ready), 64'(1));
        check("midrst_valid", 64'(m_resp_valid), 64'(0));
        check("midrst_txn", 64'(m_txn), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("no_resp_after_rst", 64'(m_resp_valid), 64'(0));
        end
        do_req(1'b0, 8'd2, 32'h0, 2, 0);
        check("rdata_addr2_old", 64'(m_resp_rdata), 64'(32'h11));

        // LATENCY=0 build.
        @(posedge clk); #1;
        sel = 1'b1;
        do_req(1'b1, 8'd1, 32'h0000_0004, 0, 0);
        do_req(1'b0, 8'd1, 32'h0, 0, 0);
        check("l0_rdata", 64'(m_resp_rdata), 64'(32'h4));

        req_write = 1'b0; req_addr = 8'd1; req_valid = 1'b1; resp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m_req_ready) acc.push_back(c);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        n_drain = 0;
        while (q.size() != 0 && n_drain < 20) begin @(posedge clk); #1; n_drain++; end
        resp_ready = 1'b0;
        check("b2b_drained", 64'(q.size()), 64'(0));
        check("b2b_accepts", 64'(acc.size() >= 3), 64'(1));
        for (int i = 1; i < acc.size(); i++)
            check("b2b_gap", 64'((acc[i] - acc[i-1]) >= 2), 64'(1));
        check("l0_txn_count", 64'(m_txn), 64'(exp_cnt[1]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
